// File: rtl/vx_launch_ctrl.sv
// rtl/vx_launch_ctrl.sv - kernel launch sequencer: DCR table write-out, core reset release, busy tracking
// Optional feature macro: VX_LAUNCH_ABORT_EN (adds abort input and aborted status output)
module vx_launch_ctrl #(
  parameter int NUM_DCRS     = 4,
  parameter int DCR_ADDR_W   = 12,
  parameter int DCR_DATA_W   = 32,
  parameter int RESET_DELAY  = 8,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int CYCLE_W      = 44
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [NUM_DCRS-1:0]            tbl_mask,
  input  logic [NUM_DCRS*DCR_ADDR_W-1:0] tbl_addr,
  input  logic [NUM_DCRS*DCR_DATA_W-1:0] tbl_data,
  output logic                           dcr_wr_valid,
  input  logic                           dcr_wr_ready,
  output logic [DCR_ADDR_W-1:0]          dcr_wr_addr,
  output logic [DCR_DATA_W-1:0]          dcr_wr_data,
  output logic                           vx_reset,
  input  logic                           vx_busy,
  output logic                           idle,
  output logic                           done,
  output logic                           timeout,
`ifdef VX_LAUNCH_ABORT_EN
  input  logic                           abort,
  output logic                           aborted,
`endif
  output logic [CYCLE_W-1:0]             cycles
);

  localparam int IDX_W   = (NUM_DCRS > 1) ? $clog2(NUM_DCRS) : 1;
  localparam int CNT_MAX = (RESET_DELAY > BUSY_TIMEOUT) ? RESET_DELAY : BUSY_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DCRS - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_DELAY - 1);
  localparam logic [CNT_W-1:0] BT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DCR   = 3'd1;
  localparam logic [2:0] S_RST   = 3'd2;
  localparam logic [2:0] S_BWAIT = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;

  logic [IDX_W-1:0]      load_idx;
  logic                  load_mask;
  logic [DCR_ADDR_W-1:0] load_addr;
  logic [DCR_DATA_W-1:0] load_data;
  logic [CYCLE_W-1:0]    cycles_inc;

  // Select the entry to present next: entry 0 when launching, otherwise the one after idx.
  always_comb begin
    load_idx  = (state == S_DCR) ? (idx + IDX_W'(1)) : '0;
    load_mask = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int i = 0; i < NUM_DCRS; i++) begin
      if (load_idx == IDX_W'(i)) begin
        load_mask = tbl_mask[i];
        load_addr = tbl_addr[i*DCR_ADDR_W +: DCR_ADDR_W];
        load_data = tbl_data[i*DCR_DATA_W +: DCR_DATA_W];
      end
    end
  end

  // Busy-cycle increment that sticks at all-ones instead of wrapping.
  always_comb begin
    cycles_inc = (&cycles) ? cycles : (cycles + CYCLE_W'(1));
  end

  // Launch sequencer: every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
      vx_reset     <= 1'b1;
      idle         <= 1'b1;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycles       <= '0;
`ifdef VX_LAUNCH_ABORT_EN
      aborted      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_DCR;
            idle         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycles       <= '0;
            idx          <= '0;
            dcr_wr_valid <= load_mask;
            if (load_mask) begin
              dcr_wr_addr <= load_addr;
              dcr_wr_data <= load_data;
            end
`ifdef VX_LAUNCH_ABORT_EN
            aborted      <= 1'b0;
`endif
          end
        end
        S_DCR: begin
          // An entry retires when it was masked off or its write was accepted.
          if (!dcr_wr_valid || dcr_wr_ready) begin
            if (idx == LAST_IDX) begin
              dcr_wr_valid <= 1'b0;
              cnt          <= '0;
              state        <= S_RST;
            end else begin
              idx          <= load_idx;
              dcr_wr_valid <= load_mask;
              if (load_mask) begin
                dcr_wr_addr <= load_addr;
                dcr_wr_data <= load_data;
              end
            end
          end
        end
        S_RST: begin
          if (cnt == RST_LAST) begin
            vx_reset <= 1'b0;
            cnt      <= '0;
            state    <= S_BWAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_BWAIT: begin
          if (vx_busy) begin
            cycles <= cycles_inc;
            state  <= S_RUN;
          end else if (cnt == BT_LAST) begin
            timeout  <= 1'b1;
            done     <= 1'b1;
            vx_reset <= 1'b1;
            idle     <= 1'b1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (vx_busy) begin
            cycles <= cycles_inc;
          end else begin
            done     <= 1'b1;
            vx_reset <= 1'b1;
            idle     <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          state        <= S_IDLE;
          dcr_wr_valid <= 1'b0;
          vx_reset     <= 1'b1;
          idle         <= 1'b1;
        end
      endcase
`ifdef VX_LAUNCH_ABORT_EN
      // Abort wins over any handshake or busy event decided above on this edge.
      if (abort && (state != S_IDLE) && (state != S_DONE)) begin
        dcr_wr_valid <= 1'b0;
        vx_reset     <= 1'b1;
        done         <= 1'b1;
        idle         <= 1'b1;
        aborted      <= 1'b1;
        state        <= S_DONE;
      end
`endif
    end
  end

endmodule

// File: doc/vx_launch_ctrl.md
Name: vx_launch_ctrl

Overview:
Synthesizable kernel-launch sequencer that sits between a host/AXI-lite control front end and the Vortex core's DCR and reset inputs. On a start command it:
- programs a table of up to NUM_DCRS DCR writes through a valid/ready port,
- holds the core in reset for RESET_DELAY cycles, then releases it,
- waits for busy to rise (with timeout), then waits for busy to fall,
- reports done or timeout, plus a busy-cycle count.

Parameters:
NUM_DCRS, 4, number of DCR table entries (>=1)
DCR_ADDR_W, 12, DCR address width
DCR_DATA_W, 32, DCR data width
RESET_DELAY, 8, cycles vx_reset is held asserted before release (>=1)
BUSY_TIMEOUT, 1024, max cycles waiting for vx_busy to rise after release (>=1)
CYCLE_W, 44, width of busy-cycle counter

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
start  input  1  launch request, sampled in IDLE or DONE only
tbl_mask  input  NUM_DCRS  bit i=1: entry i is written
tbl_addr  input  NUM_DCRS*DCR_ADDR_W  entry i at bits [i*DCR_ADDR_W +: DCR_ADDR_W]
tbl_data  input  NUM_DCRS*DCR_DATA_W  entry i at bits [i*DCR_DATA_W +: DCR_DATA_W]
dcr_wr_valid  output  1  DCR write request
dcr_wr_ready  input  1  DCR sink accepts
dcr_wr_addr  output  DCR_ADDR_W  DCR address
dcr_wr_data  output  DCR_DATA_W  DCR data
vx_reset  output  1  core reset, active-high
vx_busy  input  1  core busy
idle  output  1  high in IDLE or DONE
done  output  1  run finished (level)
timeout  output  1  busy never rose (level)
cycles  output  CYCLE_W  busy-cycle count of last/current run

Behaviour:
- Reset (resetn low at posedge) overrides everything: state=IDLE, dcr_wr_valid=0, addr/data=0, vx_reset=1, done=0, timeout=0, cycles=0, idle=1. Reset applies in any state, including mid-handshake and mid-run.
- All outputs are registered.
- States: IDLE, DCR, RST, BWAIT, RUN, DONE.
- IDLE/DONE + start:
  - clear done, timeout, cycles; index=0; go to DCR.
  - first dcr_wr_valid can appear one cycle after start is sampled.
  - start in any other state is ignored.
- DCR:
  - entries are walked in ascending index order.
  - masked-off entry: consumes one cycle with valid=0, then index+1.
  - masked-on entry: valid=1 with tbl_addr/data[index] captured into output registers.
  - valid/addr/data stay stable until valid&&ready; on that edge valid drops (or the next entry is presented back-to-back on the following cycle), index+1.
  - tbl_* are sampled only when an entry is loaded.
  - after the last index: go to RST with reset counter=0.
  - mask all-zero: NUM_DCRS idle cycles, then RST.
- vx_reset=1 in IDLE, DCR, RST and DONE; 0 in BWAIT and RUN.
- RST: counter counts 0..RESET_DELAY-1. On the edge where counter==RESET_DELAY-1, vx_reset<=0, wait counter=0, go to BWAIT. vx_reset is therefore high for exactly RESET_DELAY cycles in RST.
- BWAIT:
  - vx_busy=1: cycles+1, go to RUN.
  - else, wait counter==BUSY_TIMEOUT-1: timeout<=1, done<=1, vx_reset<=1, go to DONE.
  - else: wait counter+1.
- RUN:
  - vx_busy=1: cycles+1. cycles saturates at all-ones and does not wrap.
  - vx_busy=0: done<=1, vx_reset<=1, go to DONE.
- DONE: done/timeout/cycles hold until the next start or reset.

Optional Feature:
- Macro VX_LAUNCH_ABORT_EN.
- Defined:
  - adds input port abort (1 bit) and output port aborted (1 bit, reset 0).
  - abort sampled high in DCR, RST, BWAIT or RUN: dcr_wr_valid<=0, vx_reset<=1, done<=1, aborted<=1, go to DONE next edge.
  - abort in IDLE or DONE is ignored.
  - abort has priority over a handshake or busy event on the same edge.
  - aborted is cleared by start.
- Undefined: neither port exists; behaviour is exactly as above.

Test Plan:
- Basic launch: NUM_DCRS=4, mask=4'b0001, entry0=(0x001, 0x80000000), ready=1, vx_busy high for 100 cycles starting 5 cycles after release. Required: exactly one write 0x001/0x80000000; vx_reset high for 8 cycles in RST; done=1, timeout=0, cycles=100.
- Backpressure: mask=4'b1111, ready low for 3 cycles while entry1 is presented. Required: addr/data for entry1 stable across all 3 stall cycles; 4 handshakes in order 0,1,2,3; no duplicate writes.
- Sparse mask: mask=4'b0101. Required: only entries 0 and 2 are written; 4 cycles elapse in DCR before RST when ready=1.
- Timeout: BUSY_TIMEOUT=16, vx_busy held 0. Required: 16 cycles after release, timeout=1, done=1, vx_reset=1, cycles=0; a new start clears timeout and relaunches.
- Reset mid-run: resetn low for 1 cycle in RUN. Required: next edge state=IDLE, vx_reset=1, done=0, cycles=0, dcr_wr_valid=0.
- Abort (VX_LAUNCH_ABORT_EN defined): abort pulse in RUN on the same edge vx_busy falls. Required: aborted=1, done=1, vx_reset=1 next cycle.
